// File: rtl/aurora_rx_ctrl_if.sv
// rtl/aurora_rx_ctrl_if.sv - signal bundle between the Aurora RX link controller and its environment
// master: the controller. It takes in enable, clr_cnt, channel_up, fifo_level,
//         fifo_rst_busy, loss_data and loss_frame. It drives pma_init, reset_pb,
//         the three FIFO status flags, link_up, link_state and the three counters.
// slave:  the environment, with the opposite directions.
interface aurora_rx_ctrl_if #(
    parameter int LEVEL_W = 10,
    parameter int CNT_W   = 32
);
    logic               enable;
    logic               clr_cnt;
    logic               channel_up;
    logic [LEVEL_W-1:0] fifo_level;
    logic               fifo_rst_busy;
    logic               loss_data;
    logic               loss_frame;
    logic               pma_init;
    logic               reset_pb;
    logic               fifo_ready;
    logic               fifo_below_lwm;
    logic               fifo_above_hwm;
    logic               link_up;
    logic [2:0]         link_state;
    logic [CNT_W-1:0]   retry_cnt;
    logic [CNT_W-1:0]   loss_data_cnt;
    logic [CNT_W-1:0]   loss_frame_cnt;

    modport master (
        input  enable, clr_cnt, channel_up, fifo_level, fifo_rst_busy, loss_data, loss_frame,
        output pma_init, reset_pb, fifo_ready, fifo_below_lwm, fifo_above_hwm,
               link_up, link_state, retry_cnt, loss_data_cnt, loss_frame_cnt
    );

    modport slave (
        output enable, clr_cnt, channel_up, fifo_level, fifo_rst_busy, loss_data, loss_frame,
        input  pma_init, reset_pb, fifo_ready, fifo_below_lwm, fifo_above_hwm,
               link_up, link_state, retry_cnt, loss_data_cnt, loss_frame_cnt
    );
endinterface

// File: rtl/aurora_rx_ctrl.sv
// rtl/aurora_rx_ctrl.sv - Aurora RX lane bring-up/retry FSM, FIFO status flags and loss counters
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : aurora_rx_ctrl_if.master. Link control (enable, channel_up -> pma_init,
//                reset_pb, link_up, link_state), FIFO status (fifo_level,
//                fifo_rst_busy -> fifo_ready, fifo_below_lwm, fifo_above_hwm) and
//                counters (loss_data, loss_frame, clr_cnt -> retry/loss counts).
module aurora_rx_ctrl #(
    parameter int LEVEL_W     = 10,
    parameter int HWM         = 768,
    parameter int LWM         = 256,
    parameter int PMA_CYCLES  = 1024,
    parameter int PB_CYCLES   = 256,
    parameter int UP_TIMEOUT  = 65536,
    parameter int DOWN_CYCLES = 16,
    parameter int CNT_W       = 32
) (
    input  logic clk,
    input  logic rst_n,
    aurora_rx_ctrl_if.master bus
);
    generate
        if (!(LWM < HWM && HWM < (1 << LEVEL_W))) begin : g_bad_watermarks
            $error("aurora_rx_ctrl: watermarks must satisfy LWM < HWM < 2**LEVEL_W");
        end
        if (PMA_CYCLES < 1 || PB_CYCLES < 1 || UP_TIMEOUT < 1 || DOWN_CYCLES < 1) begin : g_bad_cycles
            $error("aurora_rx_ctrl: cycle-count parameters must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_RELEASE = 3'd2,
        ST_WAIT_UP = 3'd3,
        ST_LINKED  = 3'd4
    } state_t;

    // One down-timer serves every state, so it is sized for the largest count.
    localparam int T_MAX_A = (PMA_CYCLES > PB_CYCLES) ? PMA_CYCLES : PB_CYCLES;
    localparam int T_MAX_B = (UP_TIMEOUT > DOWN_CYCLES) ? UP_TIMEOUT : DOWN_CYCLES;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int TMR_W   = $clog2(T_MAX + 1);

    // Loaded with N-1 on entry; the state exits on the cycle the timer reads zero,
    // so each state lasts exactly N cycles.
    localparam logic [TMR_W-1:0] T_PMA  = TMR_W'(PMA_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_PB   = TMR_W'(PB_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_UP   = TMR_W'(UP_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] T_DOWN = TMR_W'(DOWN_CYCLES - 1);

    localparam logic [LEVEL_W-1:0] HWM_L   = LEVEL_W'(HWM);
    localparam logic [LEVEL_W-1:0] LWM_L   = LEVEL_W'(LWM);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    state_t             r_state;
    logic [TMR_W-1:0]   r_timer;
    logic               r_pma_init;
    logic               r_reset_pb;
    logic               r_link_up;
    logic               r_fifo_ready;
    logic               r_fifo_below_lwm;
    logic               r_fifo_above_hwm;
    logic [CNT_W-1:0]   r_retry_cnt;
    logic [CNT_W-1:0]   r_loss_data_cnt;
    logic [CNT_W-1:0]   r_loss_frame_cnt;

    logic w_timer_zero;
    logic w_retry;

    assign w_timer_zero = (r_timer == '0);

    // A retry is a WAIT_UP timeout or a LINKED loss. In both cases channel_up is low,
    // so a channel_up arriving on the timeout cycle links instead of retrying.
    // enable low overrides both.
    assign w_retry = bus.enable && !bus.channel_up && w_timer_zero &&
                     (r_state == ST_WAIT_UP || r_state == ST_LINKED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_pma_init <= 1'b1;
            r_reset_pb <= 1'b1;
            r_link_up  <= 1'b0;
        end else if (!bus.enable) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_pma_init <= 1'b1;
            r_reset_pb <= 1'b1;
            r_link_up  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_RESET;
                    r_timer <= T_PMA;
                end
                ST_RESET: begin
                    if (w_timer_zero) begin
                        r_state    <= ST_RELEASE;
                        r_timer    <= T_PB;
                        r_pma_init <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (w_timer_zero) begin
                        r_state    <= ST_WAIT_UP;
                        r_timer    <= T_UP;
                        r_reset_pb <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_WAIT_UP: begin
                    if (bus.channel_up) begin
                        r_state   <= ST_LINKED;
                        r_timer   <= T_DOWN;
                        r_link_up <= 1'b1;
                    end else if (w_timer_zero) begin
                        r_state    <= ST_RESET;
                        r_timer    <= T_PMA;
                        r_pma_init <= 1'b1;
                        r_reset_pb <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_LINKED: begin
                    // In LINKED the timer counts consecutive channel_up-low cycles.
                    if (bus.channel_up) begin
                        r_timer <= T_DOWN;
                    end else if (w_timer_zero) begin
                        r_state    <= ST_RESET;
                        r_timer    <= T_PMA;
                        r_pma_init <= 1'b1;
                        r_reset_pb <= 1'b1;
                        r_link_up  <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_timer    <= '0;
                    r_pma_init <= 1'b1;
                    r_reset_pb <= 1'b1;
                    r_link_up  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.clr_cnt) begin
            r_retry_cnt      <= '0;
            r_loss_data_cnt  <= '0;
            r_loss_frame_cnt <= '0;
        end else begin
            if (w_retry && r_retry_cnt != CNT_MAX) begin
                r_retry_cnt <= r_retry_cnt + CNT_ONE;
            end
            if (bus.loss_data && r_loss_data_cnt != CNT_MAX) begin
                r_loss_data_cnt <= r_loss_data_cnt + CNT_ONE;
            end
            if (bus.loss_frame && r_loss_frame_cnt != CNT_MAX) begin
                r_loss_frame_cnt <= r_loss_frame_cnt + CNT_ONE;
            end
        end
    end

    // While the FIFO is resetting its level is meaningless, so both watermark flags drop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fifo_ready     <= 1'b0;
            r_fifo_above_hwm <= 1'b0;
            r_fifo_below_lwm <= 1'b0;
        end else begin
            r_fifo_ready     <= !bus.fifo_rst_busy;
            r_fifo_above_hwm <= !bus.fifo_rst_busy && (bus.fifo_level >= HWM_L);
            r_fifo_below_lwm <= !bus.fifo_rst_busy && (bus.fifo_level <= LWM_L);
        end
    end

    assign bus.pma_init       = r_pma_init;
    assign bus.reset_pb       = r_reset_pb;
    assign bus.link_up        = r_link_up;
    assign bus.link_state     = r_state;
    assign bus.fifo_ready     = r_fifo_ready;
    assign bus.fifo_above_hwm = r_fifo_above_hwm;
    assign bus.fifo_below_lwm = r_fifo_below_lwm;
    assign bus.retry_cnt      = r_retry_cnt;
    assign bus.loss_data_cnt  = r_loss_data_cnt;
    assign bus.loss_frame_cnt = r_loss_frame_cnt;
endmodule

// File: tb/tb_aurora_rx_ctrl.sv
// tb/tb_aurora_rx_ctrl.sv - self-checking bench for aurora_rx_ctrl
module tb_aurora_rx_ctrl;
    localparam int LEVEL_W = 10;
    localparam int CNT_W   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aurora_rx_ctrl_if #(.LEVEL_W(LEVEL_W), .CNT_W(CNT_W)) bus ();

    aurora_rx_ctrl #(
        .LEVEL_W(LEVEL_W), .HWM(768), .LWM(256),
        .PMA_CYCLES(4), .PB_CYCLES(3), .UP_TIMEOUT(8), .DOWN_CYCLES(4),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int   level;
        logic busy;
        logic exp_ready;
        logic exp_above;
        logic exp_below;
    } fifo_vec_t;

    fifo_vec_t vecs[16];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input int st, input string tag);
        chk({tag, "_state"},    int'(bus.link_state), st);
        chk({tag, "_pma_init"}, int'(bus.pma_init),   (st <= 1) ? 1 : 0);
        chk({tag, "_reset_pb"}, int'(bus.reset_pb),   (st <= 2) ? 1 : 0);
        chk({tag, "_link_up"},  int'(bus.link_up),    (st == 4) ? 1 : 0);
    endtask

    task automatic hold(input int st, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk_state(st, tag);
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int err_above;
        int err_below;
        int lvl;

        vecs[0]  = '{0,    1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{255,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{256,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{257,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{767,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{768,  1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{769,  1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1023, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{768,  1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{767,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{257,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{256,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{0,    1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1023, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1023, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{100,  1'b0, 1'b1, 1'b0, 1'b1};

        bus.enable        = 1'b0;
        bus.clr_cnt       = 1'b0;
        bus.channel_up    = 1'b0;
        bus.fifo_level    = '0;
        bus.fifo_rst_busy = 1'b0;
        bus.loss_data     = 1'b0;
        bus.loss_frame    = 1'b0;

        // Reset values
        rst_n = 1'b0;
        tick();
        tick();
        chk_state(0, "rst");
        chk("rst_fifo_ready", int'(bus.fifo_ready),     0);
        chk("rst_above_hwm",  int'(bus.fifo_above_hwm), 0);
        chk("rst_below_lwm",  int'(bus.fifo_below_lwm), 0);
        chk("rst_retry",      int'(bus.retry_cnt),      0);
        chk("rst_loss_data",  int'(bus.loss_data_cnt),  0);
        chk("rst_loss_frame", int'(bus.loss_frame_cnt), 0);
        rst_n = 1'b1;
        tick();
        chk_state(0, "idle");

        // FIFO status vectors: unchanged before the edge, new values after it
        for (int i = 0; i < 16; i++) begin
            fifo_vec_t prev;
            prev = (i == 0) ? vecs[0] : vecs[i-1];
            bus.fifo_level    = LEVEL_W'(vecs[i].level);
            bus.fifo_rst_busy = vecs[i].busy;
            #1;
            chk($sformatf("vec%0d_pre_ready", i), int'(bus.fifo_ready),     int'(prev.exp_ready));
            chk($sformatf("vec%0d_pre_above", i), int'(bus.fifo_above_hwm), int'(prev.exp_above));
            chk($sformatf("vec%0d_pre_below", i), int'(bus.fifo_below_lwm), int'(prev.exp_below));
            tick();
            chk($sformatf("vec%0d_ready", i), int'(bus.fifo_ready),     int'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_above", i), int'(bus.fifo_above_hwm), int'(vecs[i].exp_above));
            chk($sformatf("vec%0d_below", i), int'(bus.fifo_below_lwm), int'(vecs[i].exp_below));
        end

        // Full sweep 0 -> 1023 -> 0
        err_above = 0;
        err_below = 0;
        bus.fifo_rst_busy = 1'b0;
        for (int s = 0; s < 2047; s++) begin
            lvl = (s < 1024) ? s : 2046 - s;
            bus.fifo_level = LEVEL_W'(lvl);
            tick();
            if (bus.fifo_above_hwm !== (lvl >= 768)) err_above++;
            if (bus.fifo_below_lwm !== (lvl <= 256)) err_below++;
        end
        chk("sweep_above_errors", err_above, 0);
        chk("sweep_below_errors", err_below, 0);

        // Test 1: repeated WAIT_UP timeouts
        bus.enable = 1'b1;
        tick();
        for (int k = 1; k <= 3; k++) begin
            hold(1, 4, "t1_reset");
            hold(2, 3, "t1_release");
            hold(3, 8, "t1_wait");
            chk($sformatf("t1_retry_%0d", k), int'(bus.retry_cnt), k);
        end

        // Test 2: channel_up in WAIT_UP cycle 2
        hold(1, 4, "t2_reset");
        hold(2, 3, "t2_release");
        hold(3, 1, "t2_wait");
        bus.channel_up = 1'b1;
        chk_state(3, "t2_wait2");
        tick();
        chk_state(4, "t2_linked");
        chk("t2_retry", int'(bus.retry_cnt), 3);

        // Test 3: link loss debounce
        bus.channel_up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state(4, "t3_drop3");
        end
        bus.channel_up = 1'b1;
        tick();
        chk_state(4, "t3_restore");
        bus.channel_up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state(4, "t3_drop4");
        end
        tick();
        chk_state(1, "t3_lost");
        chk("t3_retry", int'(bus.retry_cnt), 4);

        // Test 2b: channel_up on the timeout cycle itself
        hold(1, 4, "t2b_reset");
        hold(2, 3, "t2b_release");
        hold(3, 7, "t2b_wait");
        chk_state(3, "t2b_last_wait");
        bus.channel_up = 1'b1;
        tick();
        chk_state(4, "t2b_linked");
        chk("t2b_retry", int'(bus.retry_cnt), 4);

        // Test 6: enable drop in LINKED and in RESET mid-count, then reset in WAIT_UP
        bus.enable = 1'b0;
        tick();
        chk_state(0, "t6_idle_from_linked");
        chk("t6_retry_a", int'(bus.retry_cnt), 4);
        bus.channel_up = 1'b0;
        bus.enable = 1'b1;
        tick();
        chk_state(1, "t6_reset");
        tick();
        tick();
        bus.enable = 1'b0;
        tick();
        chk_state(0, "t6_idle_from_reset");
        chk("t6_retry_b", int'(bus.retry_cnt), 4);
        bus.enable = 1'b1;
        tick();
        hold(1, 4, "t6_reset_full");
        hold(2, 3, "t6_release");
        hold(3, 3, "t6_wait");
        bus.fifo_level = '0;
        bus.loss_data  = 1'b1;
        tick();
        bus.loss_data = 1'b0;
        chk("t6_pre_loss_data", int'(bus.loss_data_cnt), 1);
        rst_n = 1'b0;
        tick();
        chk_state(0, "t6_rst");
        chk("t6_rst_retry",      int'(bus.retry_cnt),      0);
        chk("t6_rst_loss_data",  int'(bus.loss_data_cnt),  0);
        chk("t6_rst_fifo_ready", int'(bus.fifo_ready),     0);
        chk("t6_rst_below_lwm",  int'(bus.fifo_below_lwm), 0);
        rst_n = 1'b1;
        bus.enable = 1'b0;
        tick();

        // Test 5: saturation and clear priority
        bus.loss_data = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("t5_loss_data_3", int'(bus.loss_data_cnt), 3);
        for (int i = 0; i < 7; i++) tick();
        chk("t5_loss_data_sat", int'(bus.loss_data_cnt), 7);
        bus.loss_data  = 1'b0;
        bus.loss_frame = 1'b1;
        tick();
        tick();
        chk("t5_loss_frame_2", int'(bus.loss_frame_cnt), 2);
        bus.clr_cnt = 1'b1;
        tick();
        chk("t5_clr_loss_frame", int'(bus.loss_frame_cnt), 0);
        chk("t5_clr_loss_data",  int'(bus.loss_data_cnt),  0);
        bus.clr_cnt = 1'b0;
        tick();
        chk("t5_after_clr", int'(bus.loss_frame_cnt), 1);
        bus.loss_frame = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
